// File: rtl/sample_sched.sv
// sample_sched
// Shares one sample-generation engine between the left and right S/PDIF
// channels. When the transmitter accepts a sample on one channel, a request
// is raised for the next sample of the opposite channel. Requests are served
// one at a time through a gen_start/gen_done handshake. Results are latched
// into per-channel holding registers, and underruns, engine timeouts and
// request overruns are counted or flagged.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   spdif_*_accepted      1-cycle pulses: transmitter consumed a holding register
//   gen_start, gen_ch     job launch pulse and channel of the current job
//   gen_done, gen_sample  engine completion pulse and its result
//   left/right_sample     holding registers feeding the transmitter
//   left/right_ready      holding register is fresh and not yet accepted
//   busy                  scheduler is not idle
//   clr_err               clears underrun_cnt, timeout_err, overrun_err
//   underrun_cnt          saturating count of accepts of a stale sample
//   timeout_err           sticky: an engine job was abandoned
//   overrun_err           sticky: a request arrived while one was still pending
module sample_sched #(
  parameter int SAMPLE_W = 16,
  parameter int TIMEOUT  = 1023,
  parameter int TO_W     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spdif_left_accepted,
  input  logic                spdif_right_accepted,
  output logic                gen_start,
  output logic                gen_ch,
  input  logic                gen_done,
  input  logic [SAMPLE_W-1:0] gen_sample,
  output logic [SAMPLE_W-1:0] left_sample,
  output logic [SAMPLE_W-1:0] right_sample,
  output logic                left_ready,
  output logic                right_ready,
  output logic                busy,
  input  logic                clr_err,
  output logic [7:0]          underrun_cnt,
  output logic                timeout_err,
  output logic                overrun_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Last WAIT cycle before the job is abandoned.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q;
  logic            pendLeft_q;
  logic            pendRight_q;
  logic            lastCh_q;
  logic [TO_W-1:0] toCnt_q;

  logic            grantValid;
  logic            grantCh;
  logic            grantLeft;
  logic            grantRight;
  logic            doneValid;
  logic            loadLeft;
  logic            loadRight;
  logic            timeoutHit;
  logic            underLeft;
  logic            underRight;
  logic            overLeft;
  logic            overRight;
  logic [7:0]      underBase;
  logic [8:0]      underSum;
  logic [7:0]      underrunCnt_d;

  // Decode this cycle's events from the registered state. Arbitration picks
  // the only pending channel, or alternates against the last served channel
  // when both are waiting. A completion on the very cycle the timeout would
  // fire counts as a completion. Overrun is only flagged when the pending
  // request is not being granted in the same cycle, since in that case the
  // new request is kept rather than merged. Underruns compare against the
  // ready value from before this cycle, and a clear in the same cycle as an
  // underrun restarts the count from zero but still records the new event.
  always_comb begin
    grantValid    = (state_q == IDLE) && (pendLeft_q || pendRight_q);
    grantCh       = (pendLeft_q && pendRight_q) ? ~lastCh_q : pendRight_q;
    grantLeft     = grantValid && !grantCh;
    grantRight    = grantValid && grantCh;
    doneValid     = (state_q == WAIT) && gen_done;
    loadLeft      = doneValid && !gen_ch;
    loadRight     = doneValid && gen_ch;
    timeoutHit    = (state_q == WAIT) && !gen_done && (toCnt_q == TO_LAST);
    underLeft     = spdif_left_accepted && !left_ready;
    underRight    = spdif_right_accepted && !right_ready;
    overLeft      = spdif_right_accepted && pendLeft_q && !grantLeft;
    overRight     = spdif_left_accepted && pendRight_q && !grantRight;
    underBase     = clr_err ? 8'd0 : underrun_cnt;
    underSum      = {1'b0, underBase} + {8'd0, underLeft} + {8'd0, underRight};
    underrunCnt_d = underSum[8] ? 8'hFF : underSum[7:0];
  end

  // All state and every output live in this one register block. Requests,
  // holding registers and error bookkeeping update every cycle; the case
  // statement walks the IDLE -> START -> WAIT job sequence and produces the
  // registered gen_start pulse, gen_ch and busy alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pendLeft_q   <= 1'b0;
      pendRight_q  <= 1'b0;
      lastCh_q     <= 1'b1;
      toCnt_q      <= '0;
      gen_start    <= 1'b0;
      gen_ch       <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      left_ready   <= 1'b0;
      right_ready  <= 1'b0;
      busy         <= 1'b0;
      underrun_cnt <= 8'd0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      // A right accept asks for the next left sample and vice versa; a new
      // request beats the grant that clears it.
      pendLeft_q  <= spdif_right_accepted | (pendLeft_q & ~grantLeft);
      pendRight_q <= spdif_left_accepted | (pendRight_q & ~grantRight);

      if (loadLeft) begin
        left_sample <= gen_sample;
      end
      if (loadRight) begin
        right_sample <= gen_sample;
      end
      left_ready  <= loadLeft | (left_ready & ~spdif_left_accepted);
      right_ready <= loadRight | (right_ready & ~spdif_right_accepted);

      underrun_cnt <= underrunCnt_d;
      timeout_err  <= timeoutHit | (timeout_err & ~clr_err);
      overrun_err  <= overLeft | overRight | (overrun_err & ~clr_err);

      gen_start <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            state_q   <= START;
            gen_start <= 1'b1;
            gen_ch    <= grantCh;
            lastCh_q  <= grantCh;
            busy      <= 1'b1;
          end
        end
        START: begin
          toCnt_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (gen_done || (toCnt_q == TO_LAST)) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            toCnt_q <= toCnt_q + TO_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
